// File: rtl/gray_codec_serial.sv
// Bit-serial binary<->Gray converter, MSB first, one bit per clock, valid/ready on both sides.
// Optional GRAY_CODEC_ADJ_CHECK_EN adds out_adj: result differs from the last delivered word in exactly one bit.
//
// Handshake rule (both ports): a transfer happens on a rising edge where valid && ready;
// a valid word is held stable until it transfers; ready never depends on valid in the same cycle.
module gray_codec_serial #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef GRAY_CODEC_ADJ_CHECK_EN
  ,
  output logic             out_adj
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] res;
  logic             mode_r;

  logic [CNT_W-1:0] hi_idx;
  logic             prev_bit;
  logic             cur_bit;
  logic [WIDTH-1:0] res_next;

  assign in_ready = (state == IDLE);

  // The neighbour above bit n is the source bit (encode) or the result bit
  // produced one cycle earlier (decode); the MSB is always passed through.
  always_comb begin
    hi_idx   = (n == LAST) ? n : n + CNT_W'(1);
    prev_bit = mode_r ? res[hi_idx] : src[hi_idx];
    cur_bit  = (n == LAST) ? src[n] : (prev_bit ^ src[n]);
    res_next = res;
    res_next[n] = cur_bit;
  end

`ifdef GRAY_CODEC_ADJ_CHECK_EN
  logic [WIDTH-1:0] last_out;
  logic             adj_next;

  always_comb begin
    adj_next = ($countones(res_next ^ last_out) == 1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      n         <= '0;
      src       <= '0;
      res       <= '0;
      mode_r    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
      out_adj   <= 1'b0;
      last_out  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src    <= in_data;
            mode_r <= mode;
            res    <= '0;
            n      <= LAST;
            state  <= CONV;
          end
        end
        CONV: begin
          res <= res_next;
          if (n == '0) begin
            out_data  <= res_next;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
            out_adj   <= adj_next;
`endif
          end else begin
            n <= n - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
            last_out  <= out_data;
`endif
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
